// File: rtl/drop_scheduler_pkg.sv
// Shared definitions for the drop scheduler: slot state encoding, LFSR taps
// and the widths both the scheduler and its arbiter agree on.
package drop_scheduler_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_WAIT    = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_FALLING = 2'd3
    } slot_state_e;

    localparam int DEFAULT_N_SLOTS = 6;
    localparam int COL_W           = 2;
    localparam int CNT_W           = 3;
    localparam int LFSR_W          = 16;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/drop_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after 'last', wrapping around. The caller registers the result.
module rr_arbiter #(
    parameter int W  = 6,
    parameter int LW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [W-1:0]  gnt,
    output logic          valid
);

    always_comb begin
        // NOTE: outputs get a default before the search so no latch is inferred.
        gnt   = '0;
        valid = 1'b0;
        // Upper half first (indices above last), then wrap to the lower half.
        for (int j = 0; j < W; j++) begin
            if (!valid && req[j] && (j > int'(last))) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
        for (int j = 0; j < W; j++) begin
            if (!valid && req[j]) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drop_scheduler.sv
// Sequences the falling-block slots: random per-slot waits, a cap on blocks
// in flight and a minimum spacing between spawns, granted round-robin.
module drop_scheduler
    import drop_scheduler_pkg::*;
#(
    parameter int          N_SLOTS    = DEFAULT_N_SLOTS,
    parameter int          MAX_ACTIVE = 4,
    parameter int          MIN_GAP    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick_mov,
    input  logic                         tick_count,
    input  logic [1:0]                   scene,
    input  logic [N_SLOTS-1:0]           land,
    output logic [N_SLOTS-1:0]           spawn,
    output logic [COL_W-1:0]             spawn_col,
    output logic [N_SLOTS-1:0]           active,
    output logic [$clog2(N_SLOTS+1)-1:0] n_active
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int NA_W  = $clog2(N_SLOTS + 1);
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_SLOTS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
    localparam logic [NA_W-1:0]  MAX_A    = NA_W'(MAX_ACTIVE);

    slot_state_e          st_q  [N_SLOTS];
    slot_state_e          st_d  [N_SLOTS];
    logic [CNT_W-1:0]     cnt_q [N_SLOTS];
    logic [CNT_W-1:0]     cnt_d [N_SLOTS];
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [N_SLOTS-1:0]   spawn_q, spawn_d;
    logic [COL_W-1:0]     spawn_col_q, spawn_col_d;
    logic [N_SLOTS-1:0]   active_q, active_d;
    logic [NA_W-1:0]      n_active_q, n_active_d;

    logic [N_SLOTS-1:0]   ready;
    logic [N_SLOTS-1:0]   gnt;
    logic                 arb_valid;
    logic                 grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 unused_scene;

    assign unused_scene = scene[1];

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            ready[i] = (st_q[i] == SLOT_READY);
        end
    end

    rr_arbiter #(
        .W  (N_SLOTS),
        .LW (IDX_W)
    ) u_arb (
        .req   (ready),
        .last  (last_q),
        .gnt   (gnt),
        .valid (arb_valid)
    );

    // Eligibility uses the registered count, i.e. before this cycle's lands.
    assign grant = scene[0] && tick_mov && (gap_q == '0) && (n_active_q < MAX_A) && arb_valid;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (gnt[i]) win_idx = IDX_W'(i);
        end
    end

    always_comb begin
        lfsr_d      = lfsr_next(lfsr_q);
        st_d        = st_q;
        cnt_d       = cnt_q;
        spawn_d     = '0;
        spawn_col_d = spawn_col_q;
        gap_d       = gap_q;
        last_d      = last_q;

        if (!scene[0]) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st_d[i]  = SLOT_IDLE;
                cnt_d[i] = '0;
            end
            gap_d  = '0;
            last_d = LAST_RST;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                unique case (st_q[i])
                    SLOT_IDLE: begin
                        st_d[i]  = SLOT_WAIT;
                        cnt_d[i] = CNT_W'(i);
                    end
                    SLOT_WAIT: begin
                        if (tick_count) begin
                            if (cnt_q[i] == '0) st_d[i] = SLOT_READY;
                            else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    SLOT_READY: begin
                        if (grant && gnt[i]) st_d[i] = SLOT_FALLING;
                    end
                    SLOT_FALLING: begin
                        if (land[i]) begin
                            st_d[i]  = SLOT_WAIT;
                            cnt_d[i] = lfsr_q[2*i+2 -: CNT_W];
                        end
                    end
                    default: st_d[i] = SLOT_IDLE;
                endcase
            end

            if (grant) begin
                spawn_d     = gnt;
                spawn_col_d = lfsr_q[LFSR_W-1 -: COL_W];
                gap_d       = GAP_LOAD;
                last_d      = win_idx;
            end else if (tick_mov && (gap_q != '0)) begin
                gap_d = gap_q - GAP_W'(1);
            end
        end

        n_active_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            active_d[i] = (st_d[i] == SLOT_FALLING);
            if (active_d[i]) n_active_d = n_active_d + NA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking only; the slot arrays are reset too because their start state is visible.
            for (int i = 0; i < N_SLOTS; i++) begin
                st_q[i]  <= SLOT_IDLE;
                cnt_q[i] <= '0;
            end
            lfsr_q      <= LFSR_SEED;
            gap_q       <= '0;
            last_q      <= LAST_RST;
            spawn_q     <= '0;
            spawn_col_q <= '0;
            active_q    <= '0;
            n_active_q  <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            gap_q       <= gap_d;
            last_q      <= last_d;
            spawn_q     <= spawn_d;
            spawn_col_q <= spawn_col_d;
            active_q    <= active_d;
            n_active_q  <= n_active_d;
        end
    end

    assign spawn     = spawn_q;
    assign spawn_col = spawn_col_q;
    assign active    = active_q;
    assign n_active  = n_active_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Bench for drop_scheduler: slot-level behavioural model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_drop_scheduler;

    localparam int N = 6;

    logic         clk;
    logic         rst_n;
    logic         tick_mov;
    logic         tick_count;
    logic [1:0]   scene;
    logic [N-1:0] land;
    logic [N-1:0] spawn;
    logic [1:0]   spawn_col;
    logic [N-1:0] active;
    logic [2:0]   n_active;

    int n_tests = 0;
    int n_fail  = 0;

    drop_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_mov   (tick_mov),
        .tick_count (tick_count),
        .scene      (scene),
        .land       (land),
        .spawn      (spawn),
        .spawn_col  (spawn_col),
        .active     (active),
        .n_active   (n_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: slot states 0=idle 1=wait 2=ready 3=falling, updated per clock edge.
    int           m_st  [N];
    int           m_cnt [N];
    int           m_gap;
    int           m_last;
    logic [15:0]  m_lfsr;
    logic [N-1:0] m_spawn;
    logic [1:0]   m_col;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        int falling;
        int win;
        int s;
        logic [15:0] l;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_st[i]  = 0;
                m_cnt[i] = 0;
            end
            m_gap   = 0;
            m_last  = N - 1;
            m_lfsr  = 16'hACE1;
            m_spawn = '0;
            m_col   = 2'b00;
            m_valid = 1'b1;
        end else begin
            l       = m_lfsr;
            m_spawn = '0;
            if (!scene[0]) begin
                for (int i = 0; i < N; i++) begin
                    m_st[i]  = 0;
                    m_cnt[i] = 0;
                end
                m_gap  = 0;
                m_last = N - 1;
            end else begin
                falling = 0;
                for (int i = 0; i < N; i++) if (m_st[i] == 3) falling++;
                win = -1;
                if (tick_mov && m_gap == 0 && falling < 4) begin
                    for (int k = 1; k <= N; k++) begin
                        s = (m_last + k) % N;
                        if (win < 0 && m_st[s] == 2) win = s;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    case (m_st[i])
                        0: begin m_st[i] = 1; m_cnt[i] = i; end
                        1: if (tick_count) begin
                               if (m_cnt[i] == 0) m_st[i] = 2;
                               else               m_cnt[i] = m_cnt[i] - 1;
                           end
                        2: if (i == win) m_st[i] = 3;
                        default: if (land[i]) begin
                               m_st[i]  = 1;
                               m_cnt[i] = int'((l >> (2 * i)) & 16'h7);
                           end
                    endcase
                end
                if (win >= 0) begin
                    m_spawn = N'(1 << win);
                    m_col   = l[15:14];
                    m_last  = win;
                    m_gap   = 2;
                end else if (tick_mov && m_gap > 0) begin
                    m_gap = m_gap - 1;
                end
            end
            m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] e_act;
        int e_n;
        if (m_valid) begin
            e_n = 0;
            for (int i = 0; i < N; i++) begin
                e_act[i] = (m_st[i] == 3);
                if (m_st[i] == 3) e_n++;
            end
            check("cyc_spawn", spawn, m_spawn);
            check("cyc_spawn_col", spawn_col, m_col);
            check("cyc_active", active, e_act);
            check("cyc_n_active", n_active, e_n);
        end
    end

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic cyc(input logic tm, input logic tc, input logic [N-1:0] ld);
        tick_mov   = tm;
        tick_count = tc;
        land       = ld;
        @(negedge clk);
        tick_mov   = 1'b0;
        tick_count = 1'b0;
        land       = '0;
    endtask

    task automatic tcs(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, '0);
    endtask

    // Pulse tick_mov until a spawn appears (bounded), then compare it.
    task automatic mov_until_spawn(input logic [N-1:0] exp, input string name);
        int k;
        k = 0;
        cyc(1'b1, 1'b0, '0);
        while (spawn == '0 && k < 8) begin
            cyc(1'b1, 1'b0, '0);
            k++;
        end
        check(name, spawn, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] exp_sp;
    logic [1:0]   col_exp;
    int           c2;

    initial begin
        rst_n      = 1'b0;
        scene      = 2'b00;
        tick_mov   = 1'b0;
        tick_count = 1'b0;
        land       = '0;

        // 1: reset values, stagger, first grant and its column
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        check("rst_spawn", spawn, 6'b0);
        check("rst_spawn_col", spawn_col, 2'b0);
        check("rst_active", active, 6'b0);
        check("rst_n_active", n_active, 3'd0);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;
        scene = 2'b01;
        cyc(1'b0, 1'b0, '0);
        check("lfsr_step1", dut.lfsr_q, 16'h59C3);
        check("model_lfsr_step1", m_lfsr, 16'h59C3);
        tcs(1);
        col_exp = m_lfsr[15:14];
        cyc(1'b1, 1'b0, '0);
        check("t1_spawn", spawn, 6'b000001);
        check("t1_spawn_col", spawn_col, col_exp);
        check("t1_active", active, 6'b000001);

        // 2: all READY, spacing of grants and the active cap
        do_reset();
        cyc(1'b0, 1'b0, '0);
        tcs(6);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b0, '0);
            case (k)
                0:       exp_sp = 6'b000001;
                3:       exp_sp = 6'b000010;
                6:       exp_sp = 6'b000100;
                9:       exp_sp = 6'b001000;
                default: exp_sp = 6'b000000;
            endcase
            check("t2_grant_seq", spawn, exp_sp);
        end
        check("t2_cap_n_active", n_active, 3'd4);
        cyc(1'b0, 1'b0, 6'b000010);
        check("t2_land_n_active", n_active, 3'd3);
        mov_until_spawn(6'b010000, "t2_slot4_after_land");

        // 3: round-robin order and wrap
        do_reset();
        cyc(1'b0, 1'b0, '0);
        tcs(8);
        mov_until_spawn(6'b000001, "t3_g0");
        mov_until_spawn(6'b000010, "t3_g1");
        mov_until_spawn(6'b000100, "t3_g2");
        mov_until_spawn(6'b001000, "t3_g3");
        cyc(1'b0, 1'b0, 6'b000011);
        mov_until_spawn(6'b010000, "t3_g4");
        mov_until_spawn(6'b100000, "t3_g5");
        cyc(1'b0, 1'b0, 6'b001000);
        tcs(8);
        mov_until_spawn(6'b000001, "t3_wrap0");
        cyc(1'b0, 1'b0, 6'b000001);
        mov_until_spawn(6'b000010, "t3_last1");
        cyc(1'b0, 1'b0, 6'b000010);
        tcs(8);
        mov_until_spawn(6'b001000, "t3_rr_from1");
        cyc(1'b0, 1'b0, 6'b100000);
        mov_until_spawn(6'b000001, "t3_rr_next");

        // 4: land reloads the counter from the LFSR; land on a WAIT slot is ignored
        do_reset();
        cyc(1'b0, 1'b0, '0);
        tcs(4);
        mov_until_spawn(6'b000001, "t4_g0");
        mov_until_spawn(6'b000010, "t4_g1");
        mov_until_spawn(6'b000100, "t4_g2");
        mov_until_spawn(6'b001000, "t4_g3");
        c2 = int'(m_lfsr[6:4]);
        cyc(1'b0, 1'b0, 6'b010100);
        check("t4_slot2_wait", dut.st_q[2], 2'd1);
        check("t4_slot2_cnt", dut.cnt_q[2], c2);
        check("t4_slot4_state", dut.st_q[4], 2'd1);
        check("t4_slot4_cnt", dut.cnt_q[4], 3'd0);
        check("t4_active", active, 6'b001011);
        tcs(c2);
        check("t4_slot2_still_wait", dut.st_q[2], 2'd1);
        tcs(1);
        check("t4_slot2_ready", dut.st_q[2], 2'd2);

        // 5: leaving play clears everything and blocks grants; re-entry restarts stagger
        scene = 2'b00;
        cyc(1'b1, 1'b0, '0);
        check("t5_active", active, 6'b0);
        check("t5_n_active", n_active, 3'd0);
        check("t5_spawn", spawn, 6'b0);
        for (int i = 0; i < N; i++) check("t5_idle", dut.st_q[i], 2'd0);
        cyc(1'b1, 1'b0, '0);
        check("t5_no_spawn", spawn, 6'b0);
        scene = 2'b01;
        cyc(1'b1, 1'b0, '0);
        check("t5_restart_no_spawn", spawn, 6'b0);
        cyc(1'b1, 1'b0, '0);
        check("t5_not_ready_yet", spawn, 6'b0);
        tcs(1);
        mov_until_spawn(6'b000001, "t5_restart_g0");

        // 6: rst_n only acts at a clock edge, and wins over a pending grant
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);
        check("t6_glitch_active", active, 6'b000001);
        check("t6_glitch_n_active", n_active, 3'd1);
        tcs(1);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, '0);
        check("t6_rst_spawn", spawn, 6'b0);
        check("t6_rst_spawn_col", spawn_col, 2'b0);
        check("t6_rst_active", active, 6'b0);
        check("t6_rst_n_active", n_active, 3'd0);
        check("t6_rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
